// File: rtl/idex_issue_pkg.sv
// idex_issue_pkg: shared widths, opcodes, stage FSM encoding and bubble constant for the diad pipe.
package idex_issue_pkg;
  localparam int SIZE_OPC = 6;
  localparam int SIZE_SRC_GP = 5;
  localparam int SIZE_TGT_GP = 5;
  localparam logic [SIZE_OPC-1:0] OPC_NOP = 6'h3f;
  typedef enum logic {RUN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic [SIZE_OPC-1:0] opc;
    logic has_src_gp;
    logic [SIZE_SRC_GP-1:0] src_gp;
    logic has_tgt_gp;
    logic [SIZE_TGT_GP-1:0] tgt_gp;
    logic tgt_gp_we;
  } ctl_t;
  // Zeroed flags keep the hazard unit's load tracking clean across bubbles.
  localparam ctl_t CTL_BUBBLE = '{opc: OPC_NOP, default: '0};
endpackage

// File: rtl/idex_issue_if.sv
// idex_issue_if: decode-side inputs, hazard controls and ID/EX outputs of the issue register.
interface idex_issue_if
  import idex_issue_pkg::*;
#(
  parameter int PC_W = 24,
  parameter int IMM_W = 24,
  parameter int CNT_W = 16
);
  logic id_valid;
  logic [PC_W-1:0] id_pc;
  logic [SIZE_OPC-1:0] id_opc;
  logic id_has_src_gp, id_has_tgt_gp, id_tgt_gp_we;
  logic [SIZE_SRC_GP-1:0] id_src_gp;
  logic [SIZE_TGT_GP-1:0] id_tgt_gp;
  logic [IMM_W-1:0] id_imm;
  logic stall, flush, if_hold;
  logic ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [SIZE_OPC-1:0] ex_opc;
  logic ex_has_src_gp, ex_has_tgt_gp, ex_tgt_gp_we;
  logic [SIZE_SRC_GP-1:0] ex_src_gp;
  logic [SIZE_TGT_GP-1:0] ex_tgt_gp;
  logic [IMM_W-1:0] ex_imm;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic stall_err;
  modport master (
    output id_valid, id_pc, id_opc, id_has_src_gp, id_has_tgt_gp, id_tgt_gp_we,
           id_src_gp, id_tgt_gp, id_imm, stall, flush,
    input  if_hold, ex_valid, ex_pc, ex_opc, ex_has_src_gp, ex_src_gp, ex_has_tgt_gp,
           ex_tgt_gp, ex_tgt_gp_we, ex_imm, stall_cnt, flush_cnt, stall_err
  );
  modport slave (
    input  id_valid, id_pc, id_opc, id_has_src_gp, id_has_tgt_gp, id_tgt_gp_we,
           id_src_gp, id_tgt_gp, id_imm, stall, flush,
    output if_hold, ex_valid, ex_pc, ex_opc, ex_has_src_gp, ex_src_gp, ex_has_tgt_gp,
           ex_tgt_gp, ex_tgt_gp_we, ex_imm, stall_cnt, flush_cnt, stall_err
  );
endinterface

// File: rtl/idex_issue_sat_counter.sv
// idex_issue_sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module idex_issue_sat_counter #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic [W-1:0] value
);
  always_ff @(posedge clk)
    value <= (rst || clr) ? '0 : (inc && !(&value)) ? value + W'(1) : value;
endmodule

// File: rtl/idex_issue.sv
// idex_issue: ID/EX issue register with stall bubbles, post-redirect drain and bring-up counters.
module idex_issue
  import idex_issue_pkg::*;
#(
  parameter int PC_W = 24,
  parameter int IMM_W = 24,
  parameter int FLUSH_SLOTS = 2,
  parameter int STALL_MAX = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  idex_issue_if.slave bus
);
  localparam int RUN_W = $clog2(STALL_MAX + 2);
  state_t state;
  logic [2:0] drain;
  logic hold, issue, stall_err;
  logic [RUN_W-1:0] run;
  ctl_t id_ctl, ex_ctl;
  logic [PC_W-1:0] ex_pc;
  logic [IMM_W-1:0] ex_imm;
  assign hold = state == RUN && !bus.flush && bus.stall && bus.id_valid;
  assign issue = state == RUN && !bus.flush && !hold;
  assign id_ctl = '{valid: bus.id_valid, opc: bus.id_opc, has_src_gp: bus.id_has_src_gp,
                    src_gp: bus.id_src_gp, has_tgt_gp: bus.id_has_tgt_gp,
                    tgt_gp: bus.id_tgt_gp, tgt_gp_we: bus.id_tgt_gp_we};
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      drain <= '0;
      ex_ctl <= CTL_BUBBLE;
      ex_pc <= '0;
      ex_imm <= '0;
      stall_err <= 1'b0;
    end else begin
      if (bus.flush) begin
        state <= DRAIN;
        drain <= 3'(FLUSH_SLOTS);
      end else if (state == DRAIN) begin
        drain <= drain - 3'd1;
        if (drain == 3'd1) state <= RUN;
      end
      ex_ctl <= issue ? id_ctl : CTL_BUBBLE;
      ex_pc <= issue ? bus.id_pc : '0;
      ex_imm <= issue ? bus.id_imm : '0;
      // This hold cycle is number STALL_MAX+1 of the current run.
      if (hold && run == RUN_W'(STALL_MAX)) stall_err <= 1'b1;
    end
  assign bus.if_hold = hold;
  assign bus.ex_valid = ex_ctl.valid;
  assign bus.ex_pc = ex_pc;
  assign bus.ex_opc = ex_ctl.opc;
  assign bus.ex_has_src_gp = ex_ctl.has_src_gp;
  assign bus.ex_src_gp = ex_ctl.src_gp;
  assign bus.ex_has_tgt_gp = ex_ctl.has_tgt_gp;
  assign bus.ex_tgt_gp = ex_ctl.tgt_gp;
  assign bus.ex_tgt_gp_we = ex_ctl.tgt_gp_we;
  assign bus.ex_imm = ex_imm;
  assign bus.stall_err = stall_err;
  idex_issue_sat_counter #(.W(RUN_W)) u_run (
    .clk(clk), .rst(rst), .inc(hold), .clr(!hold), .value(run)
  );
  idex_issue_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(hold), .clr(1'b0), .value(bus.stall_cnt)
  );
  idex_issue_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(bus.flush), .clr(1'b0), .value(bus.flush_cnt)
  );
endmodule

// File: doc/idex_issue.md
# idex_issue

ID/EX issue register for the diad pipeline, directly downstream of decode and of the load-use hazard unit. Each cycle it either issues the decoded instruction into the ID/EX register, or inserts a bubble and freezes fetch/decode when the hazard unit's stall is asserted. It also discards wrong-path instructions after a branch redirect from EX. Its registered opcode output is the ID/EX opcode that the hazard unit tracks. Saturating stall/flush counters and a sticky stall-watchdog flag support bring-up.

## Interface
Parameters:
- PC_W, 24, program-counter width
- IMM_W, 24, immediate width
- FLUSH_SLOTS, 2, wrong-path slots discarded after a flush (1..7)
- STALL_MAX, 2, longest legal run of consecutive stall cycles
- CNT_W, 16, perf counter width

Ports (clock and reset first):
- iw_clk  in  1  clock
- iw_rst  in  1  reset, synchronous, active-high
- iw_id_valid  in  1  decode slot holds an instruction
- iw_id_pc  in  PC_W  decoded PC
- iw_id_opc  in  SIZE_OPC  decoded opcode
- iw_id_has_src_gp, iw_id_has_tgt_gp, iw_id_tgt_gp_we  in  1 each  decode flags
- iw_id_src_gp  in  SIZE_SRC_GP  source register
- iw_id_tgt_gp  in  SIZE_TGT_GP  target register
- iw_id_imm  in  IMM_W  immediate
- iw_stall  in  1  hazard-unit stall
- iw_flush  in  1  branch redirect from EX
- ow_if_hold  out  1  freeze PC and IF/ID (combinational)
- ow_ex_valid, ow_ex_pc, ow_ex_opc, ow_ex_has_src_gp, ow_ex_src_gp, ow_ex_has_tgt_gp, ow_ex_tgt_gp, ow_ex_tgt_gp_we, ow_ex_imm  out  as inputs  ID/EX register
- ow_stall_cnt, ow_flush_cnt  out  CNT_W  saturating counters
- ow_stall_err  out  1  sticky watchdog flag

## Operation
- FSM states: RUN, DRAIN.
- RUN:
  - iw_flush: load a bubble, set the drain counter to FLUSH_SLOTS, go to DRAIN.
  - Otherwise, iw_stall && iw_id_valid: load a bubble and assert ow_if_hold.
  - Otherwise: load the ID fields, with ow_ex_valid = iw_id_valid.
- DRAIN:
  - Every cycle loads a bubble. ID inputs are ignored and ow_if_hold is 0.
  - The counter decrements each cycle; return to RUN when it would reach 0.
  - iw_flush while in DRAIN reloads the counter to FLUSH_SLOTS.
- Bubble contents: valid=0, opc=`OPC_NOP` (added to opcodes.vh if absent), all flags 0, registers/imm/pc 0. Zeroed fields keep the hazard unit's load tracking clean.
- Priority: flush > stall > issue. ow_if_hold = (state==RUN) && !iw_flush && iw_stall && iw_id_valid.
- iw_stall is ignored when iw_id_valid=0 and in DRAIN.
- Stall counter:
  - The run counter increments on each cycle that ow_if_hold=1 and clears on any cycle it is 0.
  - When the run reaches STALL_MAX+1, ow_stall_err sets and stays set until reset.
- ow_stall_cnt increments on each ow_if_hold cycle. ow_flush_cnt increments on each iw_flush cycle. Both saturate at all-ones and never wrap.

## Timing
- Issue latency is 1 cycle: ID fields at edge N appear on ow_ex_* after edge N.
- ow_if_hold is same-cycle combinational. Upstream must not advance in a cycle where it is 1.
- A single load-use produces exactly 2 hold cycles and 2 bubbles, matching the hazard unit's 2-deep load window.
- Flush at edge N yields FLUSH_SLOTS+1 bubbles: the edge-N load plus FLUSH_SLOTS drain cycles. The first real issue occurs at edge N+FLUSH_SLOTS+1.
- Reset values:
  - state RUN, drain counter 0, stall-run counter 0.
  - ID/EX register = bubble.
  - ow_stall_cnt=0, ow_flush_cnt=0, ow_stall_err=0.
  - ow_if_hold follows from these (0 unless iw_stall && iw_id_valid).
- Reset asserted mid-DRAIN or mid-stall returns to the reset values at the next edge, with no partial issue.

## Structure
- Use widths from sizes.vh and opcodes from opcodes.vh. The FSM state encoding and bubble constants go in a shared header (src/pipe.vh) for reuse by other stage registers.
- One natural sub-module: sat_counter (parameter W; ports inc, clr, value), instantiated for both perf counters and the stall-run counter.

## Test plan
- Straight-line issue: 4 valid instrs at PC 0x10..0x13, no stall/flush. ow_ex_pc follows 1 cycle later and ow_if_hold stays 0.
- Load-use: iw_stall=1 for 2 cycles with iw_id_valid=1. Expect 2 bubbles (opc=`OPC_NOP`, valid=0), ow_if_hold=1 for 2 cycles, then the held instr issues, ow_stall_cnt=2, ow_stall_err=0.
- Flush with FLUSH_SLOTS=2: iw_flush at cycle 5 with valid ID input. Expect bubbles at cycles 6, 7, 8, a real issue at cycle 9, and ow_flush_cnt=1.
- Flush and stall together, then a second flush at DRAIN slot 1. Flush wins with ow_if_hold=0, and the drain reloads for a total of 4 bubbles.
- Watchdog: iw_stall held for 3 cycles. ow_stall_err=1 from cycle 3 and stays 1 after the stall drops.
- Saturation and reset: CNT_W=4, 20 stall cycles. Expect ow_stall_cnt=15. A reset pulse mid-DRAIN clears all outputs to their reset values on the next edge.
